// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory-stage LSU (master) and the data memory (slave).
// Request/grant handshake with byte enables; read data returns with rvalid.
interface mem_stage_lsu_if #(
    parameter int unsigned XLEN = 32
);
    logic                dmem_req;
    logic                dmem_we;
    logic [XLEN/8-1:0]   dmem_be;
    logic [XLEN-1:0]     dmem_addr;
    logic [XLEN-1:0]     dmem_wdata;
    logic                dmem_gnt;
    logic                dmem_rvalid;
    logic [XLEN-1:0]     dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one op at a time from execute, req/gnt/rvalid bus,
// width/sign handling, misalignment and illegal-width detection, bus timeout.
module mem_stage_lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_npc,
    input  logic            ex_zero,
    mem_stage_lsu_if.master dmem,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_lmd,
    output logic [1:0]      wb_err,
    output logic [XLEN-1:0] condpc
);
    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            op_load;
    logic [1:0]      op_size;
    logic            op_uns;
    logic [OFF-1:0]  op_off;

    logic [1:0]      ex_size;
    logic [OFF-1:0]  ex_off;
    logic            ex_is_mem;
    logic            ex_illegal;
    logic            ex_misaligned;
    logic [NB-1:0]   size_be;
    logic [NB-1:0]   ex_be;
    logic [XLEN-1:0] ex_wrep;

    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] keep;
    logic            sbit;
    logic [XLEN-1:0] ld_ext;
    logic            timeout_hit;

    assign ex_ready = (state == IDLE);
    assign condpc   = ex_zero ? ex_addr : ex_npc;
    assign ex_size  = ex_funct3[1:0];
    assign ex_off   = ex_addr[OFF-1:0];

    // Counter never passes TIMEOUT-1: the cycle it would reach TIMEOUT is the timeout cycle.
    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt) == TIMEOUT - 1);

    // Decode of the operation presented by execute.
    always_comb begin
        ex_is_mem = ex_mem_read | ex_mem_write;
        if (ex_mem_read) begin
            unique case (ex_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ex_illegal = 1'b0;
                3'b110, 3'b011:                         ex_illegal = (XLEN != 64);
                default:                                ex_illegal = 1'b1;
            endcase
        end else begin
            ex_illegal = ex_funct3[2] | ((ex_funct3[1:0] == 2'b11) && (XLEN != 64));
        end
        ex_misaligned = (ex_off & OFF'((4'd1 << ex_size) - 4'd1)) != '0;

        unique case (ex_size)
            2'd0:    size_be = NB'(4'h1);
            2'd1:    size_be = NB'(4'h3);
            2'd2:    size_be = NB'(4'hF);
            default: size_be = '1;
        endcase
        ex_be = size_be << ex_off;

        unique case (ex_size)
            2'd0:    ex_wrep = {NB{ex_wdata[7:0]}};
            2'd1:    ex_wrep = {(NB/2){ex_wdata[15:0]}};
            2'd2:    ex_wrep = {(NB/4){ex_wdata[31:0]}};
            default: ex_wrep = ex_wdata;
        endcase
    end

    // Load data: bring the addressed lane to bit 0, then sign- or zero-extend.
    always_comb begin
        rd_shift = dmem.dmem_rdata >> {op_off, 3'b000};
        unique case (op_size)
            2'd0:    begin keep = XLEN'(8'hFF);         sbit = rd_shift[7];  end
            2'd1:    begin keep = XLEN'(16'hFFFF);      sbit = rd_shift[15]; end
            2'd2:    begin keep = XLEN'(32'hFFFF_FFFF); sbit = rd_shift[31]; end
            default: begin keep = '1;                   sbit = 1'b0;         end
        endcase
        ld_ext = (rd_shift & keep) | ((sbit & ~op_uns) ? ~keep : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            op_load          <= 1'b0;
            op_size          <= '0;
            op_uns           <= 1'b0;
            op_off           <= '0;
            dmem.dmem_req    <= 1'b0;
            dmem.dmem_we     <= 1'b0;
            dmem.dmem_be     <= '0;
            dmem.dmem_addr   <= '0;
            dmem.dmem_wdata  <= '0;
            wb_valid         <= 1'b0;
            wb_rd            <= '0;
            wb_lmd           <= '0;
            wb_err           <= ERR_OK;
        end else begin
            wb_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (ex_valid) begin
                        op_load <= ex_mem_read;
                        op_size <= ex_size;
                        op_uns  <= ex_funct3[2];
                        op_off  <= ex_off;
                        wb_rd   <= ex_rd;
                        if (!ex_is_mem) begin
                            state    <= RESP;
                            wb_valid <= 1'b1;
                            wb_err   <= ERR_OK;
                        end else if (ex_illegal) begin
                            state    <= RESP;
                            wb_valid <= 1'b1;
                            wb_err   <= ERR_ILLEGAL;
                        end else if (ex_misaligned) begin
                            state    <= RESP;
                            wb_valid <= 1'b1;
                            wb_err   <= ERR_MISALIGN;
                        end else begin
                            state           <= REQ;
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= ex_mem_write;
                            dmem.dmem_be    <= ex_be;
                            dmem.dmem_addr  <= {ex_addr[XLEN-1:OFF], {OFF{1'b0}}};
                            dmem.dmem_wdata <= ex_mem_write ? ex_wrep : '0;
                        end
                    end
                end
                REQ: begin
                    if (dmem.dmem_gnt && (!op_load || dmem.dmem_rvalid)) begin
                        dmem.dmem_req <= 1'b0;
                        state         <= RESP;
                        wb_valid      <= 1'b1;
                        wb_err        <= ERR_OK;
                        if (op_load) begin
                            wb_lmd <= ld_ext;
                        end
                    end else if (timeout_hit) begin
                        dmem.dmem_req <= 1'b0;
                        state         <= RESP;
                        wb_valid      <= 1'b1;
                        wb_err        <= ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (dmem.dmem_gnt) begin
                            dmem.dmem_req <= 1'b0;
                            state         <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem.dmem_rvalid) begin
                        state    <= RESP;
                        wb_valid <= 1'b1;
                        wb_err   <= ERR_OK;
                        wb_lmd   <= ld_ext;
                    end else if (timeout_hit) begin
                        state    <= RESP;
                        wb_valid <= 1'b1;
                        wb_err   <= ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized + directed bench for mem_stage_lsu (XLEN=32, TIMEOUT=4) against a
// behavioural model of the width, alignment, latency and timeout rules.
module tb_mem_stage_lsu;
    localparam int unsigned XLEN = 32;
    localparam int unsigned TO   = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ex_valid = 1'b0;
    logic            ex_ready;
    logic            ex_mem_read = 1'b0;
    logic            ex_mem_write = 1'b0;
    logic [2:0]      ex_funct3 = '0;
    logic [XLEN-1:0] ex_addr = '0;
    logic [XLEN-1:0] ex_wdata = '0;
    logic [4:0]      ex_rd = '0;
    logic [XLEN-1:0] ex_npc = '0;
    logic            ex_zero = 1'b0;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_lmd;
    logic [1:0]      wb_err;
    logic [XLEN-1:0] condpc;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_lmd = '0;
    int unsigned last_n, last_nreq;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata;

    always #5 clk = ~clk;

    mem_stage_lsu_if #(.XLEN(XLEN)) dmem ();

    mem_stage_lsu #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_rd(ex_rd), .ex_npc(ex_npc), .ex_zero(ex_zero),
        .dmem(dmem),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_lmd(wb_lmd), .wb_err(wb_err),
        .condpc(condpc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_err(input bit mr, input bit mw, input logic [2:0] f3,
                                             input logic [31:0] addr);
        bit legal;
        int unsigned nbytes;
        if (!mr && !mw) return 2'b00;
        legal = mr ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        if (!legal) return 2'b11;
        nbytes = 1 << f3[1:0];
        if ((addr % nbytes) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int unsigned nbits;
        logic [63:0] v;
        nbits = 8 << f3[1:0];
        v = (64'(rdata) >> (8 * (addr % 4))) & ((64'd1 << nbits) - 64'd1);
        if (!f3[2] && v[nbits-1]) v = v - (64'd1 << nbits);
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        int unsigned nbytes;
        logic [63:0] lane, acc;
        nbytes = 1 << f3[1:0];
        lane = 64'(wdata) & ((64'd1 << (8 * nbytes)) - 64'd1);
        acc = '0;
        for (int unsigned i = 0; i < 4 / nbytes; i++) acc = acc | (lane << (8 * nbytes * i));
        return acc[31:0];
    endfunction

    // One operation with a scripted memory: gnt after gd extra req cycles,
    // rvalid rdl cycles after gnt (0 = together with gnt).
    task automatic do_op(input bit mr, input bit mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input int unsigned gd, input int unsigned rdl, input logic [31:0] rval);
        logic [1:0]  e;
        int unsigned exp_n, exp_nreq, total, n, nreq, w;
        logic [3:0]  exp_be;
        bit          granted, got;

        e = model_err(mr, mw, f3, addr);
        exp_be = 4'(((32'd1 << (1 << f3[1:0])) - 1) << (addr % 4));
        if (!(mr || mw) || e != 2'b00) begin
            exp_n = 1;
            exp_nreq = 0;
        end else begin
            total = gd + 1 + (mr ? rdl : 0);
            if (total > TO) begin
                e = 2'b10;
                exp_n = 1 + TO;
                exp_nreq = (gd + 1 < TO) ? gd + 1 : TO;
            end else begin
                exp_n = 1 + total;
                exp_nreq = gd + 1;
                if (mr) exp_lmd = model_load(f3, addr, rval);
            end
        end

        @(negedge clk);
        check("ready_idle", ex_ready, 1);
        check("wb_one_cycle", wb_valid, 0);
        ex_valid = 1'b1; ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
        ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
        ex_zero = 1'($urandom_range(0, 1)); ex_npc = $urandom;
        #1 check("condpc", condpc, ex_zero ? addr : ex_npc);
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_addr = $urandom; ex_wdata = $urandom; ex_rd = 5'($urandom);

        n = 1; nreq = 0; w = 0; granted = 0; got = 0;
        obs_be = '0; obs_addr = '0; obs_wdata = '0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (wb_valid) begin
                got = 1;
            end else begin
                dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = $urandom;
                if (dmem.dmem_req) begin
                    nreq++;
                    if (nreq == 1) begin
                        obs_be = dmem.dmem_be; obs_addr = dmem.dmem_addr; obs_wdata = dmem.dmem_wdata;
                        check("bus_we", dmem.dmem_we, mw);
                        check("bus_be", dmem.dmem_be, exp_be);
                        check("bus_addr", dmem.dmem_addr, addr & ~32'd3);
                        if (mw) check("bus_wdata", dmem.dmem_wdata, model_wdata(f3, wdata));
                    end
                    if (nreq > gd) begin
                        dmem.dmem_gnt = 1'b1;
                        granted = 1;
                        if (mr && rdl == 0) begin dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = rval; end
                    end
                end else if (granted && mr) begin
                    w++;
                    if (w == rdl) begin dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = rval; end
                end
                @(negedge clk);
                n++;
            end
        end
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0;
        last_n = n; last_nreq = nreq;

        check("wb_seen", got, 1);
        if (got) begin
            check("latency", n, exp_n);
            check("req_cycles", nreq, exp_nreq);
            check("wb_err", wb_err, e);
            check("wb_rd", wb_rd, rd);
            check("wb_lmd", wb_lmd, exp_lmd);
            check("ready_resp", ex_ready, 0);
        end
    endtask

    // Abort a load by reset while it is stalled in REQ or WAIT.
    task automatic reset_mid_op(input bit in_wait);
        bit seen;
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h400; ex_rd = 5'd9;
        @(negedge clk);
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        check("rst_req_up", dmem.dmem_req, 1);
        if (in_wait) begin
            dmem.dmem_gnt = 1'b1;
            @(negedge clk);
            dmem.dmem_gnt = 1'b0;
            check("rst_wait_req", dmem.dmem_req, 0);
        end else begin
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("rst_req_drop", dmem.dmem_req, 0);
        check("rst_ready", ex_ready, 1);
        exp_lmd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (wb_valid) seen = 1;
        end
        check("rst_no_wb", seen, 0);
    endtask

    initial begin
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req", dmem.dmem_req, 0);
        check("rst_we", dmem.dmem_we, 0);
        check("rst_be", dmem.dmem_be, 0);
        check("rst_addr", dmem.dmem_addr, 0);
        check("rst_wdata", dmem.dmem_wdata, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_lmd", wb_lmd, 0);
        check("rst_wb_err", wb_err, 0);
        check("rst_ex_ready", ex_ready, 1);
        rst_n = 1'b1;

        ex_zero = 1'b1; ex_addr = 32'h40; ex_npc = 32'h24;
        #1 check("condpc_taken", condpc, 32'h40);
        ex_zero = 1'b0;
        #1 check("condpc_seq", condpc, 32'h24);

        do_op(1, 0, 3'b000, 32'h101, 32'h0, 5'd1, 0, 0, 32'h8081_F2F3);
        check("lb_value", wb_lmd, 32'hFFFF_FFF2);
        check("lb_be", obs_be, 4'b0010);
        check("lb_addr", obs_addr, 32'h100);
        do_op(1, 0, 3'b100, 32'h101, 32'h0, 5'd2, 1, 1, 32'h8081_F2F3);
        check("lbu_value", wb_lmd, 32'h0000_00F2);
        do_op(1, 0, 3'b001, 32'h102, 32'h0, 5'd3, 0, 2, 32'h8081_F2F3);
        check("lh_value", wb_lmd, 32'hFFFF_8081);
        do_op(1, 0, 3'b101, 32'h102, 32'h0, 5'd4, 2, 0, 32'h8081_F2F3);
        check("lhu_value", wb_lmd, 32'h0000_8081);

        do_op(1, 0, 3'b010, 32'h300, 32'h0, 5'd5, 10, 0, 32'h1234_5678);
        check("to_err", wb_err, 2'b10);
        check("to_req_cycles", last_nreq, 4);
        check("to_lmd_hold", wb_lmd, 32'h0000_8081);

        do_op(0, 1, 3'b000, 32'h203, 32'h0000_00AB, 5'd6, 0, 0, 32'h0);
        check("sb_be", obs_be, 4'b1000);
        check("sb_wdata", obs_wdata, 32'hABAB_ABAB);
        do_op(0, 1, 3'b010, 32'h10, 32'hCAFE_F00D, 5'd7, 0, 0, 32'h0);
        check("sw_latency", last_n, 2);
        check("sw_err", wb_err, 2'b00);
        do_op(1, 0, 3'b010, 32'h102, 32'h0, 5'd8, 0, 0, 32'h0);
        check("lw_mis_err", wb_err, 2'b01);
        check("lw_mis_latency", last_n, 1);
        check("lw_mis_noreq", last_nreq, 0);
        do_op(1, 0, 3'b011, 32'h0, 32'h0, 5'd9, 0, 0, 32'h0);
        check("ld_illegal", wb_err, 2'b11);

        reset_mid_op(0);
        reset_mid_op(1);
        do_op(1, 0, 3'b010, 32'h404, 32'h0, 5'd10, 0, 1, 32'h7654_3210);
        check("lw_after_rst", wb_lmd, 32'h7654_3210);

        for (int i = 0; i < 80; i++) begin
            int unsigned kind;
            bit mr, mw;
            logic [31:0] a;
            kind = $urandom_range(0, 4);
            mr = (kind == 1 || kind == 2);
            mw = (kind >= 3);
            a = $urandom & ~32'h3;
            if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 3));
            do_op(mr, mw, 3'($urandom_range(0, 7)), a, $urandom, 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
        end

        @(negedge clk);
        check("final_wb_low", wb_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised load/store unit for the memory stage of the RISC-V pipeline, sitting between execute and writeback.
- Accepts one operation at a time from execute and drives a req/gnt/rvalid data-memory bus with byte enables.
- Handles all RISC-V load/store widths, including sign/zero extension and misalignment detection.
- Times out stuck bus transactions.
- Produces the load memory data (LMD) and the conditional PC for writeback/fetch.

Parameters:
XLEN, 32, datapath width; 32 or 64. OFF = log2(XLEN/8) address offset bits.
TIMEOUT, 255, max cycles in REQ+WAIT before bus-timeout error; 0 disables timeout.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute presents an operation
ex_ready  out  1  unit can accept (IDLE only)
ex_mem_read  in  1  load op
ex_mem_write  in  1  store op (never both with mem_read)
ex_funct3  in  3  RISC-V width/sign code
ex_addr  in  XLEN  effective address (ALU result)
ex_wdata  in  XLEN  store data (rs2)
ex_rd  in  5  destination register
ex_npc  in  XLEN  next sequential PC
ex_zero  in  1  branch-taken flag
dmem_req  out  1  bus request
dmem_we  out  1  write enable
dmem_be  out  XLEN/8  byte enables
dmem_addr  out  XLEN  address, offset bits forced to 0
dmem_wdata  out  XLEN  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  XLEN  read data
wb_valid  out  1  one-cycle completion pulse
wb_rd  out  5  destination register of completed op
wb_lmd  out  XLEN  extended load data
wb_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
condpc  out  XLEN  ex_zero ? ex_addr : ex_npc (combinational)

Behaviour:
- Reset (async): state IDLE; all registered outputs 0 (dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_rd, wb_lmd, wb_err); timeout counter 0.
- Reset mid-transaction aborts it: req drops immediately; no wb_valid is produced.
- States and transitions:
  - IDLE: ex_ready=1. On ex_valid, latch op, address and data, then:
    - non-memory op -> RESP
    - illegal or misaligned op -> RESP with error
    - otherwise -> REQ
  - REQ: dmem_req=1; bus outputs are stable until gnt.
    - gnt & store -> RESP
    - gnt & load & rvalid -> RESP
    - gnt & load & !rvalid -> WAIT
  - WAIT: dmem_req=0; rvalid -> RESP.
  - RESP: wb_valid=1 for exactly one cycle -> IDLE.
- Latency (accept at cycle T):
  - non-memory op: wb_valid at T+1.
  - zero-wait load/store (gnt, plus rvalid for loads, at T+1): wb_valid at T+2.
  - each wait cycle adds one cycle.
- Width rules (funct3):
  - 000 LB, 100 LBU, 001 LH, 101 LHU, 010 LW, 110 LWU, 011 LD.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
  - 110 and 011 are legal only when XLEN=64; other codes are illegal (err 11, no bus access).
- Misaligned (err 01, no bus access): half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0.
- Byte enables: size mask shifted left by addr[OFF-1:0]. Store data is replicated across every lane of its size.
- Load extraction: select bytes at the offset, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to XLEN.
- wb_lmd updates only on a successful load completion. It holds its value otherwise, and is unchanged on error.
- wb_rd is valid with wb_valid.
- Timeout: counter increments each cycle in REQ/WAIT and clears on entering IDLE. When it reaches TIMEOUT: RESP with err 10, dmem_req drops. The memory contract forbids a response after a timeout; rvalid/gnt seen in IDLE or RESP are ignored.
- ex_valid outside IDLE is not accepted; execute must hold it until ex_ready.

Test Plan:
- Reset mid-op: LW issued and stalled in WAIT, rst_n pulsed low -> dmem_req=0 immediately, no wb_valid; after release, the next LW completes normally.
- Byte/half loads: XLEN=32, rdata=0x8081_F2F3.
  - LB addr 0x101 -> wb_lmd 0xFFFF_FFF2; LBU -> 0x0000_00F2.
  - LH addr 0x102 -> 0xFFFF_8081; LHU -> 0x0000_8081.
  - be=0010 for the byte loads; dmem_addr 0x100.
- Stores: SB addr 0x203, wdata 0x0000_00AB -> be=1000, dmem_wdata=0xABAB_ABAB.
- Zero-wait timing: SW addr 0x10 with gnt at T+1 -> wb_valid at T+2, wb_err=00.
- Misaligned and illegal ops:
  - LW addr 0x102 -> no dmem_req, wb_valid at T+1 with err 01.
  - LD with XLEN=32 -> err 11.
- Timeout: TIMEOUT=4, gnt held low -> req high 4 cycles, then wb_err=10; wb_lmd keeps its previous value.
- condpc: ex_zero=1, ex_addr=0x40, ex_npc=0x24 -> 0x40; ex_zero=0 -> 0x24.
